// File: rtl/fdas_ddr_amm_arbiter.sv
// Two-requester round-robin, burst-locked arbiter in front of the EMIF Avalon-MM user port.
// Read returns are steered back to their owner through a tag FIFO of outstanding read bursts.
module fdas_ddr_amm_arbiter #(
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 576,
    parameter int BE_W      = 72,
    parameter int BURST_W   = 7,
    parameter int TAG_DEPTH = 16
) (
    input  logic                   emif_usr_clk,
    input  logic                   emif_usr_reset_n,
    input  logic                   cal_success,
    input  logic [1:0]             req_read,
    input  logic [1:0]             req_write,
    input  logic [2*ADDR_W-1:0]    req_address,
    input  logic [2*BURST_W-1:0]   req_burstcount,
    input  logic [2*DATA_W-1:0]    req_writedata,
    input  logic [2*BE_W-1:0]      req_byteenable,
    output logic [1:0]             req_ready,
    output logic [DATA_W-1:0]      req_readdata,
    output logic [1:0]             req_readdatavalid,
    output logic                   amm_read,
    output logic                   amm_write,
    output logic [ADDR_W-1:0]      amm_address,
    output logic [BURST_W-1:0]     amm_burstcount,
    output logic [DATA_W-1:0]      amm_writedata,
    output logic [BE_W-1:0]        amm_byteenable,
    input  logic                   amm_ready,
    input  logic [DATA_W-1:0]      amm_readdata,
    input  logic                   amm_readdatavalid,
    output logic                   rsp_err
);

    localparam int PTR_W = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2
    } state_t;

    state_t               state_r, state_nxt_s;
    logic                 gnt_r, gnt_nxt_s;
    logic                 last_r, last_nxt_s;
    logic [BURST_W-1:0]   wcnt_r, wcnt_nxt_s;
    logic [PTR_W:0]       wr_ptr_r, rd_ptr_r;
    logic                 fifo_tag_r [TAG_DEPTH];
    logic [BURST_W-1:0]   fifo_bc_r  [TAG_DEPTH];
    logic [BURST_W-1:0]   rbeat_r;
    logic                 rsp_err_r;

    logic                 sel_read_s, sel_write_s, cmd_rd_s, cmd_wr_s, gnt_ready_s;
    logic [BURST_W-1:0]   sel_bc_s;
    logic [1:0]           elig_s;
    logic                 push_s, fifo_full_s, fifo_empty_s;
    logic                 head_tag_s, rbeat_s, rd_last_s, pop_s;
    logic [BURST_W-1:0]   head_bc_s, head_eff_s;

    // Granted requester's command fields are muxed straight onto the controller port.
    assign sel_read_s     = req_read[gnt_r];
    assign sel_write_s    = req_write[gnt_r];
    assign sel_bc_s       = gnt_r ? req_burstcount[2*BURST_W-1:BURST_W] : req_burstcount[BURST_W-1:0];
    assign amm_address    = gnt_r ? req_address[2*ADDR_W-1:ADDR_W]      : req_address[ADDR_W-1:0];
    assign amm_writedata  = gnt_r ? req_writedata[2*DATA_W-1:DATA_W]    : req_writedata[DATA_W-1:0];
    assign amm_byteenable = gnt_r ? req_byteenable[2*BE_W-1:BE_W]       : req_byteenable[BE_W-1:0];
    assign amm_burstcount = sel_bc_s;

    assign elig_s       = {2{cal_success}} & (req_read | req_write);
    assign cmd_rd_s     = sel_read_s;
    assign cmd_wr_s     = sel_write_s & ~sel_read_s;
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                          (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);

    // Arbitration and command/write-burst sequencing.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        last_nxt_s  = last_r;
        wcnt_nxt_s  = wcnt_r;
        amm_read    = 1'b0;
        amm_write   = 1'b0;
        req_ready   = 2'b00;
        gnt_ready_s = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (elig_s == 2'b11) begin
                    gnt_nxt_s   = ~last_r;
                    state_nxt_s = ST_CMD;
                end else if (elig_s[0]) begin
                    gnt_nxt_s   = 1'b0;
                    state_nxt_s = ST_CMD;
                end else if (elig_s[1]) begin
                    gnt_nxt_s   = 1'b1;
                    state_nxt_s = ST_CMD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                amm_read    = cmd_rd_s & ~fifo_full_s;
                amm_write   = cmd_wr_s;
                gnt_ready_s = amm_ready & ~(cmd_rd_s & fifo_full_s);
                req_ready   = gnt_r ? {gnt_ready_s, 1'b0} : {1'b0, gnt_ready_s};
                if (amm_read && amm_ready) begin
                    push_s      = 1'b1;
                    last_nxt_s  = gnt_r;
                    state_nxt_s = ST_IDLE;
                end else if (cmd_wr_s && amm_ready) begin
                    if (sel_bc_s <= BURST_W'(1)) begin
                        last_nxt_s  = gnt_r;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        wcnt_nxt_s  = sel_bc_s - BURST_W'(1);
                        state_nxt_s = ST_WDATA;
                    end
                end else begin
                    state_nxt_s = ST_CMD;
                end
            end
            ST_WDATA: begin
                amm_write   = sel_write_s;
                gnt_ready_s = amm_ready;
                req_ready   = gnt_r ? {gnt_ready_s, 1'b0} : {1'b0, gnt_ready_s};
                if (sel_write_s && amm_ready) begin
                    if (wcnt_r == BURST_W'(1)) begin
                        last_nxt_s  = gnt_r;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        wcnt_nxt_s  = wcnt_r - BURST_W'(1);
                    end
                end else begin
                    wcnt_nxt_s = wcnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state; last_r starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            state_r <= ST_IDLE;
            gnt_r   <= 1'b0;
            last_r  <= 1'b1;
            wcnt_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            last_r  <= last_nxt_s;
            wcnt_r  <= wcnt_nxt_s;
        end
    end

    // Read return: head entry owns every beat until its burst is complete.
    assign head_tag_s        = fifo_tag_r[rd_ptr_r[PTR_W-1:0]];
    assign head_bc_s         = fifo_bc_r[rd_ptr_r[PTR_W-1:0]];
    assign head_eff_s        = (head_bc_s == '0) ? BURST_W'(1) : head_bc_s;
    assign rbeat_s           = amm_readdatavalid & ~fifo_empty_s;
    assign rd_last_s         = (rbeat_r == head_eff_s - BURST_W'(1));
    assign pop_s             = rbeat_s & rd_last_s;
    assign req_readdata      = amm_readdata;
    assign req_readdatavalid = rbeat_s ? (head_tag_s ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_err           = rsp_err_r;

    // Tag FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge emif_usr_clk) begin
        if (push_s) begin
            fifo_tag_r[wr_ptr_r[PTR_W-1:0]] <= gnt_r;
            fifo_bc_r[wr_ptr_r[PTR_W-1:0]]  <= sel_bc_s;
        end
    end

    // Tag FIFO pointers, return beat counter and sticky orphan-beat error.
    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            rbeat_r   <= '0;
            rsp_err_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
            end
            if (rbeat_s) begin
                rbeat_r <= rd_last_s ? '0 : rbeat_r + BURST_W'(1);
            end
            if (amm_readdatavalid && fifo_empty_s) begin
                rsp_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fdas_ddr_amm_arbiter.sv
// Scoreboard bench for fdas_ddr_amm_arbiter: directed requester traffic, a simple controller
// model, and a monitor that checks every accepted command and every returned read beat.
module tb_fdas_ddr_amm_arbiter;
    localparam int ADDR_W = 27, DATA_W = 576, BE_W = 72, BURST_W = 7, TAG_DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n, cal;
    logic [1:0] req_read, req_write, req_ready, req_readdatavalid;
    logic [2*ADDR_W-1:0] req_address;
    logic [2*BURST_W-1:0] req_burstcount;
    logic [2*DATA_W-1:0] req_writedata;
    logic [2*BE_W-1:0] req_byteenable;
    logic [DATA_W-1:0] req_readdata, amm_writedata, amm_readdata;
    logic amm_read, amm_write, amm_ready, amm_readdatavalid, rsp_err;
    logic [ADDR_W-1:0] amm_address;
    logic [BURST_W-1:0] amm_burstcount;
    logic [BE_W-1:0] amm_byteenable;

    fdas_ddr_amm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
                           .BURST_W(BURST_W), .TAG_DEPTH(TAG_DEPTH)) dut (
        .emif_usr_clk(clk), .emif_usr_reset_n(rst_n), .cal_success(cal),
        .req_read(req_read), .req_write(req_write), .req_address(req_address),
        .req_burstcount(req_burstcount), .req_writedata(req_writedata),
        .req_byteenable(req_byteenable), .req_ready(req_ready),
        .req_readdata(req_readdata), .req_readdatavalid(req_readdatavalid),
        .amm_read(amm_read), .amm_write(amm_write), .amm_address(amm_address),
        .amm_burstcount(amm_burstcount), .amm_writedata(amm_writedata),
        .amm_byteenable(amm_byteenable), .amm_ready(amm_ready),
        .amm_readdata(amm_readdata), .amm_readdatavalid(amm_readdatavalid),
        .rsp_err(rsp_err));

    always #5 clk = ~clk;

    typedef struct packed { logic rd; logic owner; logic [31:0] val; logic last; } exp_t;
    typedef struct packed { logic rd; logic [31:0] addr; logic [6:0] bc; logic [31:0] dbase; } drv_t;

    exp_t exp_cmd[$];
    logic [1:0] exp_rdv[$];
    drv_t drv_q0[$], drv_q1[$];
    int n_chk = 0, n_pass = 0;
    int wr_acc_cnt = 0;
    int pulse_cnt = 0;
    bit ret_auto = 1'b1, ready_rand = 1'b0, drv_flush = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Queue a requester command and record what the controller port must show for it.
    task automatic issue(input int n, input logic rd, input logic [31:0] addr,
                         input logic [6:0] bc, input logic [31:0] dbase);
        drv_t d;
        exp_t e;
        int beats;
        d = '{rd, addr, bc, dbase};
        if (n == 0) drv_q0.push_back(d); else drv_q1.push_back(d);
        beats = (bc == 7'd0) ? 1 : int'(bc);
        if (rd) begin
            e = '{1'b1, n[0], addr, 1'b1};
            exp_cmd.push_back(e);
            for (int k = 0; k < beats; k++) exp_rdv.push_back((n == 0) ? 2'b01 : 2'b10);
        end else begin
            for (int k = 0; k < beats; k++) begin
                e = '{1'b0, n[0], dbase + 32'(k), (k == beats - 1)};
                exp_cmd.push_back(e);
            end
        end
    endtask

    task automatic wait_drain(input string name, input int maxc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            @(negedge clk);
            if (exp_cmd.size() == 0 && exp_rdv.size() == 0) done = 1'b1;
        end
        chk(name, done, 1'b1);
    endtask

    // Requester driver: holds each command/beat until req_ready was seen.
    initial begin
        drv_t cur[2];
        bit act[2], acc[2];
        int beat[2];
        logic [1:0] rd_v, wr_v;
        logic [2*ADDR_W-1:0] ad_v;
        logic [2*BURST_W-1:0] bc_v;
        logic [2*DATA_W-1:0] wd_v;
        act = '{1'b0, 1'b0};
        beat = '{0, 0};
        req_read = 2'b00; req_write = 2'b00; req_address = '0; req_burstcount = '0;
        req_writedata = '0; req_byteenable = '1;
        forever begin
            @(negedge clk);
            for (int n = 0; n < 2; n++)
                acc[n] = rst_n && req_ready[n] && (req_read[n] || req_write[n]);
            @(posedge clk);
            #1;
            if (drv_flush) begin
                drv_q0.delete(); drv_q1.delete();
                act = '{1'b0, 1'b0};
            end else begin
                for (int n = 0; n < 2; n++) begin
                    if (act[n] && acc[n]) begin
                        if (cur[n].rd) act[n] = 1'b0;
                        else begin
                            beat[n]++;
                            if (beat[n] >= ((cur[n].bc == 7'd0) ? 1 : int'(cur[n].bc))) act[n] = 1'b0;
                        end
                    end
                    if (!act[n]) begin
                        if (n == 0 && drv_q0.size() > 0) begin
                            cur[n] = drv_q0.pop_front(); act[n] = 1'b1; beat[n] = 0;
                        end else if (n == 1 && drv_q1.size() > 0) begin
                            cur[n] = drv_q1.pop_front(); act[n] = 1'b1; beat[n] = 0;
                        end
                    end
                end
            end
            rd_v = 2'b00; wr_v = 2'b00; ad_v = '0; bc_v = '0; wd_v = '0;
            for (int n = 0; n < 2; n++) begin
                rd_v[n] = act[n] & cur[n].rd;
                wr_v[n] = act[n] & ~cur[n].rd;
                ad_v[n*ADDR_W +: ADDR_W] = cur[n].addr[ADDR_W-1:0];
                bc_v[n*BURST_W +: BURST_W] = cur[n].bc;
                wd_v[n*DATA_W +: 32] = cur[n].dbase + 32'(beat[n]);
            end
            req_read = rd_v; req_write = wr_v; req_address = ad_v;
            req_burstcount = bc_v; req_writedata = wd_v;
        end
    end

    // Controller model: tracks outstanding read beats and returns them when enabled.
    initial begin
        int pend, pdone;
        logic [31:0] pat;
        pend = 0; pdone = 0; pat = 32'hA000_0000;
        amm_ready = 1'b1; amm_readdatavalid = 1'b0; amm_readdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) pend = 0;
            else begin
                if (amm_read && amm_ready) pend += (amm_burstcount == 7'd0) ? 1 : int'(amm_burstcount);
                if (amm_readdatavalid && pend > 0) pend--;
            end
            @(posedge clk);
            #1;
            amm_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pulse_cnt != pdone) begin
                pdone++;
                amm_readdatavalid = 1'b1;
            end else begin
                amm_readdatavalid = ret_auto && pend > 0;
            end
            pat = pat + 32'd1;
            amm_readdata = {18{pat}};
        end
    end

    // Monitor: pops the scoreboard on every accepted command and every returned beat.
    initial begin
        bit in_wb;
        logic owner_wb;
        exp_t e;
        logic [1:0] er;
        in_wb = 1'b0; owner_wb = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) in_wb = 1'b0;
            else begin
                if (in_wb) chk("burst_block", req_ready[~owner_wb], 1'b0);
                if ((amm_read || amm_write) && amm_ready) begin
                    if (exp_cmd.size() == 0) chk("unexpected_cmd", {amm_read, amm_write}, 2'b00);
                    else begin
                        e = exp_cmd.pop_front();
                        chk("cmd_kind", amm_read, e.rd);
                        chk("cmd_val", e.rd ? 32'(amm_address) : amm_writedata[31:0], e.val);
                        chk("cmd_ready", req_ready, e.owner ? 2'b10 : 2'b01);
                        if (!e.rd) begin
                            wr_acc_cnt++;
                            in_wb = !e.last;
                            owner_wb = e.owner;
                        end
                    end
                end
                if (amm_readdatavalid) begin
                    er = (exp_rdv.size() > 0) ? exp_rdv.pop_front() : 2'b00;
                    chk("rdv_steer", req_readdatavalid, er);
                    chk("rd_data", req_readdata[31:0], amm_readdata[31:0]);
                end else begin
                    chk("rdv_idle", req_readdatavalid, 2'b00);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit hit;
        rst_n = 1'b0; cal = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_amm_read", amm_read, 1'b0);
        chk("rst_amm_write", amm_write, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rdv", req_readdatavalid, 2'b00);
        chk("rst_rsp_err", rsp_err, 1'b0);
        rst_n = 1'b1;

        // No grants before calibration, both requesters reading.
        issue(0, 1'b1, 32'h100, 7'd4, 32'h0);
        issue(1, 1'b1, 32'h200, 7'd4, 32'h0);
        repeat (50) begin
            @(negedge clk);
            chk("nocal_amm_read", amm_read, 1'b0);
            chk("nocal_req_ready", req_ready, 2'b00);
        end
        cal = 1'b1;
        wait_drain("two_reads_drain", 200);

        // r1 write burst of 8 with a stalling controller, r0 read pending behind it.
        ready_rand = 1'b1;
        issue(1, 1'b0, 32'h300, 7'd8, 32'h1000);
        repeat (3) @(negedge clk);
        issue(0, 1'b1, 32'h380, 7'd1, 32'h0);
        wait_drain("wburst_drain", 400);
        ready_rand = 1'b0;

        // Tie after r0 was last: r1 read wins, then r0 write with burstcount 0 is a single beat.
        issue(1, 1'b1, 32'h3E0, 7'd2, 32'h0);
        issue(0, 1'b0, 32'h3C0, 7'd0, 32'h2000);
        wait_drain("rr_bc0_drain", 200);

        // 17 single-beat reads with no return: the 17th stalls on a full tag FIFO.
        ret_auto = 1'b0;
        for (int i = 0; i < 17; i++) issue(0, 1'b1, 32'h400 + 32'(i), 7'd1, 32'h0);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (exp_cmd.size() == 1) hit = 1'b1;
        end
        chk("full_16_issued", hit, 1'b1);
        repeat (5) @(negedge clk);
        chk("full_amm_read", amm_read, 1'b0);
        chk("full_req_ready", req_ready, 2'b00);
        chk("full_pending", exp_cmd.size(), 1);
        pulse_cnt++;
        @(negedge clk);
        @(negedge clk);
        chk("release_amm_read", amm_read, 1'b1);
        chk("release_req_ready", req_ready, 2'b01);
        ret_auto = 1'b1;
        wait_drain("full_drain", 200);

        // Orphan read-data beat.
        chk("err_before", rsp_err, 1'b0);
        pulse_cnt++;
        repeat (2) @(negedge clk);
        chk("err_set", rsp_err, 1'b1);
        repeat (5) @(negedge clk);
        chk("err_sticky", rsp_err, 1'b1);

        // Reset in the middle of beat 3 of an 8-beat write.
        base = wr_acc_cnt;
        issue(0, 1'b0, 32'h500, 7'd8, 32'h3000);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (wr_acc_cnt >= base + 2) hit = 1'b1;
        end
        chk("beat2_reached", hit, 1'b1);
        @(posedge clk);
        #3;
        chk("beat3_write", amm_write, 1'b1);
        rst_n = 1'b0;
        drv_flush = 1'b1;
        #1;
        chk("async_rst_write", amm_write, 1'b0);
        chk("async_rst_ready", req_ready, 2'b00);
        exp_cmd.delete();
        exp_rdv.delete();
        repeat (3) @(negedge clk);
        drv_flush = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_read", amm_read, 1'b0);
        chk("post_rst_write", amm_write, 1'b0);
        chk("post_rst_ready", req_ready, 2'b00);
        chk("post_rst_err", rsp_err, 1'b0);
        pulse_cnt++;
        repeat (2) @(negedge clk);
        chk("post_rst_fifo_empty", rsp_err, 1'b1);
        issue(1, 1'b1, 32'h600, 7'd2, 32'h0);
        wait_drain("post_rst_read_drain", 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
